// File: rtl/data_ram_pkg.sv
// Shared types for the data memory: word, byte-strobe and RUN/HALT state.
package data_ram_pkg;

   typedef logic [31:0] word;
   typedef logic [3:0]  strb_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } ram_state_e;

   localparam logic [12:0] TOHOST_DEFAULT = 13'h1FFC;

endpackage

// File: rtl/data_ram_if.sv
// MEM-stage bus into the data memory: address, combinational read data, strobed write, and halt status.
// Handshake: none; a write happens on the rising clk edge whenever w_en=1 and w_strb!=0 while the memory is in RUN.
interface data_ram_if import data_ram_pkg::*; #(
   parameter int ADDR_W = 13
);

   logic [ADDR_W-1:0] addr;
   word               r_data;
   logic              w_en;
   strb_t             w_strb;
   word               w_data;
   logic              halted;
   logic [30:0]       exit_code;
   word               wr_count;

   modport master (
      output addr, w_en, w_strb, w_data,
      input  r_data, halted, exit_code, wr_count
   );

   modport slave (
      input  addr, w_en, w_strb, w_data,
      output r_data, halted, exit_code, wr_count
   );

endinterface

// File: rtl/data_ram_tohost.sv
// tohost register, RUN/HALT state machine, captured exit code and saturating accepted-write counter.
module data_ram_tohost import data_ram_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        w_req_i,
   input  logic        tohost_sel_i,
   input  strb_t       w_strb_i,
   input  word         w_data_i,
   output logic        accept_o,
   output logic        halted_o,
   output logic [30:0] exit_code_o,
   output word         wr_count_o,
   output word         tohost_o,
   output ram_state_e  state_o
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]  state_q, state_d;
   word         tohost_q, tohost_d;
   logic [30:0] exit_code_q, exit_code_d;
   word         wr_count_q, wr_count_d;

   // A write landing on the same edge as reset must not take effect anywhere.
   assign accept_o = w_req_i & (state_q == ST_RUN) & ~rst;

   always_comb begin
      state_d     = state_q;
      tohost_d    = tohost_q;
      exit_code_d = exit_code_q;
      wr_count_d  = wr_count_q;
      if (accept_o) begin
         if (wr_count_q != 32'hFFFF_FFFF) begin
            wr_count_d = wr_count_q + 32'd1;
         end
         if (tohost_sel_i) begin
            for (int i = 0; i < 4; i++) begin
               if (w_strb_i[i]) begin
                  tohost_d[8*i +: 8] = w_data_i[8*i +: 8];
               end
            end
            // Halt is decided on the merged value, so a partial store can complete a pending bit 0.
            if (tohost_d[0]) begin
               state_d     = ST_HALT;
               exit_code_d = tohost_d[31:1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         tohost_q    <= '0;
         exit_code_q <= '0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         tohost_q    <= tohost_d;
         exit_code_q <= exit_code_d;
         wr_count_q  <= wr_count_d;
      end
   end

   assign halted_o    = (state_q == ST_HALT);
   assign exit_code_o = exit_code_q;
   assign wr_count_o  = wr_count_q;
   assign tohost_o    = tohost_q;
   assign state_o     = ram_state_e'(state_q);

endmodule

// File: rtl/data_ram.sv
// Byte-addressable data memory: combinational word read, byte-strobed synchronous write, tohost halt word.
module data_ram import data_ram_pkg::*; #(
   parameter int                ADDR_W      = 13,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_DEFAULT)
) (
   input  logic       clk,
   input  logic       rst,
   data_ram_if.slave  bus,
   output ram_state_e state_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [ADDR_W-3:0] word_addr;
   logic              tohost_sel;
   logic              w_req;
   logic              accept;
   logic              mem_we;
   word               tohost;
   logic [1:0]        unused_addr_lsbs;

   logic [7:0] mem_q [DEPTH];

   initial begin : zero_fill
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] = 8'h00;
      end
   end

   assign word_addr        = bus.addr[ADDR_W-1:2];
   assign unused_addr_lsbs = bus.addr[1:0];
   assign tohost_sel       = (word_addr == TOHOST_ADDR[ADDR_W-1:2]);
   assign w_req            = bus.w_en & (|bus.w_strb);
   assign mem_we           = accept & ~tohost_sel;

   data_ram_tohost u_tohost (
      .clk          (clk),
      .rst          (rst),
      .w_req_i      (w_req),
      .tohost_sel_i (tohost_sel),
      .w_strb_i     (bus.w_strb),
      .w_data_i     (bus.w_data),
      .accept_o     (accept),
      .halted_o     (bus.halted),
      .exit_code_o  (bus.exit_code),
      .wr_count_o   (bus.wr_count),
      .tohost_o     (tohost),
      .state_o      (state_o)
   );

   // mem has no reset: contents survive rst and only change on accepted writes.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.w_strb[i]) begin
               mem_q[{word_addr, 2'(i)}] <= bus.w_data[8*i +: 8];
            end
         end
      end
   end

   assign bus.r_data = tohost_sel ? tohost
                                  : {mem_q[{word_addr, 2'd3}], mem_q[{word_addr, 2'd2}],
                                     mem_q[{word_addr, 2'd1}], mem_q[{word_addr, 2'd0}]};

endmodule
